trdb_packet_serializer: RTL and testbench

Parametrised packet emitter with byte-stream output. It accepts one trace-packet request per handshake (formats 1, 2 and 3), assembles the payload at configurable XLEN and branch-map depth, and computes the payload length. Format 1/2 addresses are optionally differential against the last reported address. It emits a length-prefixed frame over a valid/ready stream of `OUT_BYTES` bytes per beat. It sits between the trace filter/branch-map logic and the trace sink or encapsulator.

---
 rtl/trdb_packet_serializer_if.sv | 67 ++++++
 rtl/trdb_packet_serializer.sv | 192 +++++++++++++++++++
 tb/tb_trdb_packet_serializer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trdb_packet_serializer_if.sv
// Request, configuration, output-stream and status signals of the trace
// packet serializer. The slave modport is the serializer's view; the master
// modport is the view of whatever feeds requests and consumes the stream.
interface trdb_packet_serializer_if #(
  parameter int XLEN      = 32,
  parameter int PRIV_W    = 2,
  parameter int CAUSE_W   = 5,
  parameter int BMAP_LEN  = 31,
  parameter int IOPT_W    = 4,
  parameter int OUT_BYTES = 1
);
  localparam int BCNT_W = $clog2(BMAP_LEN + 1);

  // Request handshake and packet selection
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [1:0]             format_i;
  logic [1:0]             subformat_i;

  // Payload fields
  logic                   branch_i;
  logic [PRIV_W-1:0]      priv_i;
  logic [XLEN-1:0]        iaddr_i;
  logic [CAUSE_W-1:0]     ecause_i;
  logic                   interrupt_i;
  logic                   thaddr_i;
  logic [XLEN-1:0]        tval_i;
  logic                   ienable_i;
  logic                   encoder_mode_i;
  logic [1:0]             qual_status_i;
  logic [IOPT_W-1:0]      ioptions_i;
  logic [BCNT_W-1:0]      branches_i;
  logic [BMAP_LEN-1:0]    branch_map_i;
  logic                   updiscon_i;
  logic                   irreport_i;

  // Configuration
  logic                   full_addr_i;

  // Output byte stream
  logic [8*OUT_BYTES-1:0] data_o;
  logic                   valid_o;
  logic                   ready_i;
  logic                   last_o;

  // Status pulses
  logic                   branch_map_flush_o;
  logic                   dropped_o;

  modport master (
    output in_valid_i, format_i, subformat_i,
    output branch_i, priv_i, iaddr_i, ecause_i, interrupt_i, thaddr_i, tval_i,
    output ienable_i, encoder_mode_i, qual_status_i, ioptions_i,
    output branches_i, branch_map_i, updiscon_i, irreport_i, full_addr_i,
    output ready_i,
    input  in_ready_o, data_o, valid_o, last_o, branch_map_flush_o, dropped_o
  );

  modport slave (
    input  in_valid_i, format_i, subformat_i,
    input  branch_i, priv_i, iaddr_i, ecause_i, interrupt_i, thaddr_i, tval_i,
    input  ienable_i, encoder_mode_i, qual_status_i, ioptions_i,
    input  branches_i, branch_map_i, updiscon_i, irreport_i, full_addr_i,
    input  ready_i,
    output in_ready_o, data_o, valid_o, last_o, branch_map_flush_o, dropped_o
  );
endinterface

// File: rtl/trdb_packet_serializer.sv
// Trace packet serializer: accepts one packet request per handshake, packs the
// payload LSB-first, prefixes a length header byte and streams the frame out
// OUT_BYTES bytes per beat, lowest byte first.
module trdb_packet_serializer #(
  parameter int XLEN      = 32,
  parameter int PRIV_W    = 2,
  parameter int CAUSE_W   = 5,
  parameter int BMAP_LEN  = 31,
  parameter int IOPT_W    = 4,
  parameter int OUT_BYTES = 1
) (
  input logic                      clk_i,
  input logic                      rst_i,
  trdb_packet_serializer_if.slave  bus
);

  localparam int BCNT_W = $clog2(BMAP_LEN + 1);

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int nbytes(input int bits);
    return (bits + 7) / 8;
  endfunction

  // Header byte plus payload, rounded up to whole beats.
  function automatic int nbeats(input int bits);
    return (nbytes(bits) + OUT_BYTES) / OUT_BYTES;
  endfunction

  // Payload bit counts per packet kind (fmt and sf are 2 bits each).
  localparam int START_BITS = 4 + 1 + PRIV_W + XLEN;
  localparam int TRAP_BITS  = 4 + 1 + PRIV_W + CAUSE_W + 2 + 2 * XLEN;
  localparam int CTX_BITS   = 4 + PRIV_W;
  localparam int SUP_BITS   = 4 + 4 + IOPT_W;
  localparam int F2_BITS    = 2 + XLEN + 2;
  localparam int F1A_BITS   = 2 + BCNT_W + BMAP_LEN + XLEN + 2;
  localparam int F1N_BITS   = 2 + BCNT_W + BMAP_LEN;

  localparam int MAX_BITS  = max_i(max_i(max_i(START_BITS, TRAP_BITS), max_i(CTX_BITS, SUP_BITS)),
                                   max_i(F2_BITS, max_i(F1A_BITS, F1N_BITS)));
  localparam int PAY_BYTES = nbytes(MAX_BITS);
  localparam int PAY_W     = 8 * PAY_BYTES;
  localparam int BUF_W     = PAY_W + 8;
  localparam int BEAT_W    = 8 * OUT_BYTES;
  localparam int CNT_W     = $clog2(PAY_BYTES + 2);

  localparam logic [BCNT_W-1:0] BMAP_LEN_C = BCNT_W'(BMAP_LEN);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [XLEN-1:0]    last_addr_q;
  logic               flush_q, drop_q;

  logic               in_ready, valid, accept, handshake;
  logic [XLEN-1:0]    addr;
  logic [PAY_W-1:0]   payload;
  logic [4:0]         pay_len;
  logic [CNT_W-1:0]   n_beats;
  logic               frame_en, addr_bearing;

  assign addr      = bus.full_addr_i ? bus.iaddr_i : bus.iaddr_i - last_addr_q;
  assign accept    = in_ready & bus.in_valid_i;
  assign handshake = valid & bus.ready_i;

  // Payload assembly, length and beat count for the request on the inputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    payload      = '0;
    pay_len      = '0;
    n_beats      = '0;
    frame_en     = 1'b0;
    addr_bearing = 1'b0;
    case (bus.format_i)
      2'd3: begin
        frame_en = 1'b1;
        case (bus.subformat_i)
          2'd0: begin
            payload      = PAY_W'({bus.iaddr_i, bus.priv_i, bus.branch_i,
                                   bus.subformat_i, bus.format_i});
            pay_len      = 5'(nbytes(START_BITS));
            n_beats      = CNT_W'(nbeats(START_BITS));
            addr_bearing = 1'b1;
          end
          2'd1: begin
            payload      = PAY_W'({bus.tval_i, bus.iaddr_i, bus.thaddr_i, bus.interrupt_i,
                                   bus.ecause_i, bus.priv_i, bus.branch_i,
                                   bus.subformat_i, bus.format_i});
            pay_len      = 5'(nbytes(TRAP_BITS));
            n_beats      = CNT_W'(nbeats(TRAP_BITS));
            addr_bearing = 1'b1;
          end
          2'd2: begin
            payload = PAY_W'({bus.priv_i, bus.subformat_i, bus.format_i});
            pay_len = 5'(nbytes(CTX_BITS));
            n_beats = CNT_W'(nbeats(CTX_BITS));
          end
          default: begin
            payload = PAY_W'({bus.ioptions_i, bus.qual_status_i, bus.encoder_mode_i,
                              bus.ienable_i, bus.subformat_i, bus.format_i});
            pay_len = 5'(nbytes(SUP_BITS));
            n_beats = CNT_W'(nbeats(SUP_BITS));
          end
        endcase
      end
      2'd2: begin
        frame_en     = 1'b1;
        payload      = PAY_W'({bus.irreport_i, bus.updiscon_i, addr, bus.format_i});
        pay_len      = 5'(nbytes(F2_BITS));
        n_beats      = CNT_W'(nbeats(F2_BITS));
        addr_bearing = 1'b1;
      end
      2'd1: begin
        frame_en = 1'b1;
        if (bus.branches_i < BMAP_LEN_C) begin
          payload      = PAY_W'({bus.irreport_i, bus.updiscon_i, addr, bus.branch_map_i,
                                 bus.branches_i, bus.format_i});
          pay_len      = 5'(nbytes(F1A_BITS));
          n_beats      = CNT_W'(nbeats(F1A_BITS));
          addr_bearing = 1'b1;
        end else begin
          // A full branch map carries no address.
          payload = PAY_W'({bus.branch_map_i, bus.branches_i, bus.format_i});
          pay_len = 5'(nbytes(F1N_BITS));
          n_beats = CNT_W'(nbeats(F1N_BITS));
        end
      end
      default: ;  // fmt 0 is dropped: no frame, no address update
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and state-decoded handshake outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    valid    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid_i && frame_en) state_d = SEND;
      end
      SEND: begin
        valid = 1'b1;
        if (bus.ready_i && cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift buffer, beat counter, last reported address and status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the shift buffer is reset as well, so data_o reads zero and a cut frame leaves nothing behind.
      buf_q       <= '0;
      cnt_q       <= '0;
      last_addr_q <= '0;
      flush_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      flush_q <= accept && (bus.format_i == 2'd1);
      drop_q  <= accept && (bus.format_i == 2'd0);
      if (accept && frame_en) begin
        buf_q <= {payload, 3'b000, pay_len};
        cnt_q <= n_beats;
      end else if (handshake) begin
        // Zeros shift in, which also supplies the pad bytes of the last beat.
        buf_q <= buf_q >> BEAT_W;
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (accept && addr_bearing) last_addr_q <= bus.iaddr_i;
    end
  end

  assign bus.in_ready_o         = in_ready;
  assign bus.valid_o            = valid;
  assign bus.data_o             = buf_q[BEAT_W-1:0];
  assign bus.last_o             = valid && (cnt_q == CNT_W'(1));
  assign bus.branch_map_flush_o = flush_q;
  assign bus.dropped_o          = drop_q;

endmodule

// File: tb/tb_trdb_packet_serializer.sv
// Self-checking bench for trdb_packet_serializer: a narrow (1 byte/beat) and a
// wide (4 bytes/beat) instance, with expected beats queued at accept time and
// compared as the stream comes out.
module tb_trdb_packet_serializer;

  localparam int XLEN     = 32;
  localparam int PRIV_W   = 2;
  localparam int CAUSE_W  = 5;
  localparam int BMAP_LEN = 31;
  localparam int IOPT_W   = 4;
  localparam int BCNT_W   = $clog2(BMAP_LEN + 1);

  typedef struct {
    logic [1:0]          fmt, sf;
    logic                branch;
    logic [PRIV_W-1:0]   priv;
    logic [XLEN-1:0]     iaddr;
    logic [CAUSE_W-1:0]  ecause;
    logic                interrupt, thaddr;
    logic [XLEN-1:0]     tval;
    logic                ienable, encoder_mode;
    logic [1:0]          qual;
    logic [IOPT_W-1:0]   iopt;
    logic [BCNT_W-1:0]   branches;
    logic [BMAP_LEN-1:0] bmap;
    logic                updiscon, irreport, full_addr;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trdb_packet_serializer_if #(.OUT_BYTES(1)) n_if ();
  trdb_packet_serializer_if #(.OUT_BYTES(4)) w_if ();

  trdb_packet_serializer #(.OUT_BYTES(1)) dut_n (.clk_i(clk), .rst_i(rst), .bus(n_if.slave));
  trdb_packet_serializer #(.OUT_BYTES(4)) dut_w (.clk_i(clk), .rst_i(rst), .bus(w_if.slave));

  int          n_vec = 0;
  int          n_err = 0;
  beat_t       exp_n[$];
  beat_t       exp_w[$];
  logic [XLEN-1:0] n_last = '0;
  logic [XLEN-1:0] w_last = '0;
  bit          mb[$];

  function automatic req_t zero_req();
    req_t r;
    r.fmt = '0; r.sf = '0; r.branch = '0; r.priv = '0; r.iaddr = '0; r.ecause = '0;
    r.interrupt = '0; r.thaddr = '0; r.tval = '0; r.ienable = '0; r.encoder_mode = '0;
    r.qual = '0; r.iopt = '0; r.branches = '0; r.bmap = '0; r.updiscon = '0;
    r.irreport = '0; r.full_addr = '0;
    return r;
  endfunction

  task automatic apply(input req_t r);
    n_if.format_i = r.fmt;        w_if.format_i = r.fmt;
    n_if.subformat_i = r.sf;      w_if.subformat_i = r.sf;
    n_if.branch_i = r.branch;     w_if.branch_i = r.branch;
    n_if.priv_i = r.priv;         w_if.priv_i = r.priv;
    n_if.iaddr_i = r.iaddr;       w_if.iaddr_i = r.iaddr;
    n_if.ecause_i = r.ecause;     w_if.ecause_i = r.ecause;
    n_if.interrupt_i = r.interrupt; w_if.interrupt_i = r.interrupt;
    n_if.thaddr_i = r.thaddr;     w_if.thaddr_i = r.thaddr;
    n_if.tval_i = r.tval;         w_if.tval_i = r.tval;
    n_if.ienable_i = r.ienable;   w_if.ienable_i = r.ienable;
    n_if.encoder_mode_i = r.encoder_mode; w_if.encoder_mode_i = r.encoder_mode;
    n_if.qual_status_i = r.qual;  w_if.qual_status_i = r.qual;
    n_if.ioptions_i = r.iopt;     w_if.ioptions_i = r.iopt;
    n_if.branches_i = r.branches; w_if.branches_i = r.branches;
    n_if.branch_map_i = r.bmap;   w_if.branch_map_i = r.bmap;
    n_if.updiscon_i = r.updiscon; w_if.updiscon_i = r.updiscon;
    n_if.irreport_i = r.irreport; w_if.irreport_i = r.irreport;
    n_if.full_addr_i = r.full_addr; w_if.full_addr_i = r.full_addr;
  endtask

  task automatic put(input logic [63:0] v, input int w);
    for (int i = 0; i < w; i++) mb.push_back(v[i]);
  endtask

  // Reference model: builds the frame bit by bit, splits it into beats and
  // (optionally) queues them; tracks the last reported address.
  task automatic model_push(input req_t r, input bit wide, input bit push_en);
    logic [XLEN-1:0] la, addr;
    logic [7:0]      fb[$];
    logic [7:0]      byt;
    int              nbits, len, ob, nb;
    beat_t           bt;
    bit              ab;
    if (r.fmt == 2'd0) return;
    la   = wide ? w_last : n_last;
    addr = r.full_addr ? r.iaddr : r.iaddr - la;
    mb.delete();
    ab = 1'b0;
    put(64'(r.fmt), 2);
    if (r.fmt == 2'd3) begin
      put(64'(r.sf), 2);
      case (r.sf)
        2'd0: begin put(64'(r.branch), 1); put(64'(r.priv), PRIV_W); put(64'(r.iaddr), XLEN); ab = 1'b1; end
        2'd1: begin
          put(64'(r.branch), 1); put(64'(r.priv), PRIV_W); put(64'(r.ecause), CAUSE_W);
          put(64'(r.interrupt), 1); put(64'(r.thaddr), 1); put(64'(r.iaddr), XLEN);
          put(64'(r.tval), XLEN); ab = 1'b1;
        end
        2'd2: put(64'(r.priv), PRIV_W);
        default: begin
          put(64'(r.ienable), 1); put(64'(r.encoder_mode), 1);
          put(64'(r.qual), 2); put(64'(r.iopt), IOPT_W);
        end
      endcase
    end else if (r.fmt == 2'd2) begin
      put(64'(addr), XLEN); put(64'(r.updiscon), 1); put(64'(r.irreport), 1); ab = 1'b1;
    end else begin
      put(64'(r.branches), BCNT_W); put(64'(r.bmap), BMAP_LEN);
      if (int'(r.branches) < BMAP_LEN) begin
        put(64'(addr), XLEN); put(64'(r.updiscon), 1); put(64'(r.irreport), 1); ab = 1'b1;
      end
    end
    nbits = mb.size();
    len   = (nbits + 7) / 8;
    fb.push_back(8'(len % 32));
    for (int i = 0; i < len; i++) begin
      byt = '0;
      for (int k = 0; k < 8; k++) if (i * 8 + k < nbits) byt[k] = mb[i * 8 + k];
      fb.push_back(byt);
    end
    ob = wide ? 4 : 1;
    nb = (fb.size() + ob - 1) / ob;
    if (push_en) begin
      for (int b = 0; b < nb; b++) begin
        bt.data = '0;
        for (int k = 0; k < ob; k++) if (b * ob + k < fb.size()) bt.data[8*k +: 8] = fb[b * ob + k];
        bt.last = (b == nb - 1);
        if (wide) exp_w.push_back(bt); else exp_n.push_back(bt);
      end
    end
    if (ab) begin
      if (wide) w_last = r.iaddr; else n_last = r.iaddr;
    end
  endtask

  // Present a request, wait (bounded) for acceptance, queue its expected beats.
  // Returns #1 after the accepting edge.
  task automatic send(input req_t r, input bit wide, input bit push_en);
    bit ok = 1'b0;
    apply(r);
    if (wide) w_if.in_valid_i = 1'b1; else n_if.in_valid_i = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if ((wide ? w_if.in_ready_o : n_if.in_ready_o) === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready_o stayed low, got 0 expected 1");
    end else begin
      @(posedge clk);
      model_push(r, wide, push_en);
      #1;
    end
    n_if.in_valid_i = 1'b0;
    w_if.in_valid_i = 1'b0;
  endtask

  // Consume one frame. mode 0: ready held high; mode 1: ready 1,0,0 repeating.
  task automatic drain(input bit wide, input int mode, output int hs);
    logic        v, l, ir, fl, dr, rdy;
    logic [31:0] d;
    beat_t       e;
    bit          done = 1'b0;
    hs = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      rdy = (mode == 0) ? 1'b1 : (c % 3 == 0);
      if (wide) w_if.ready_i = rdy; else n_if.ready_i = rdy;
      v  = wide ? w_if.valid_o : n_if.valid_o;
      l  = wide ? w_if.last_o : n_if.last_o;
      d  = wide ? w_if.data_o : 32'(n_if.data_o);
      ir = wide ? w_if.in_ready_o : n_if.in_ready_o;
      fl = wide ? w_if.branch_map_flush_o : n_if.branch_map_flush_o;
      dr = wide ? w_if.dropped_o : n_if.dropped_o;
      if (c == 0) begin
        n_vec++;
        if (v !== 1'b1) begin n_err++; $display("FAIL first_beat_latency: valid_o got %b expected 1", v); end
      end else begin
        n_vec++;
        if ({fl, dr} !== 2'b00) begin n_err++; $display("FAIL pulse_width: flush/dropped got %b expected 00", {fl, dr}); end
      end
      if (v === 1'b1) begin
        n_vec++;
        if (ir !== 1'b0) begin n_err++; $display("FAIL in_ready_in_send: got %b expected 0", ir); end
        n_vec++;
        if ((wide ? exp_w.size() : exp_n.size()) == 0) begin
          n_err++; $display("FAIL unexpected_beat: got data %h last %b expected no beat", d, l);
          done = 1'b1;
        end else begin
          e = wide ? exp_w[0] : exp_n[0];
          if (d !== e.data || l !== e.last) begin
            n_err++;
            $display("FAIL beat%0d: got data %h last %b expected data %h last %b", hs, d, l, e.data, e.last);
          end
          if (rdy) begin
            if (wide) void'(exp_w.pop_front()); else void'(exp_n.pop_front());
            hs++;
            if (l === 1'b1) done = 1'b1;
          end
        end
      end
    end
    @(posedge clk); #1;
    n_if.ready_i = 1'b1;
    w_if.ready_i = 1'b1;
    n_vec++;
    if (!done) begin n_err++; $display("FAIL drain_timeout: frame not finished, got %0d handshakes", hs); end
    n_vec++;
    if ((wide ? exp_w.size() : exp_n.size()) != 0) begin
      n_err++; $display("FAIL leftover_beats: got %0d expected 0", wide ? exp_w.size() : exp_n.size());
    end
  endtask

  task automatic push_lit(input logic [7:0] b[$]);
    beat_t bt;
    for (int i = 0; i < b.size(); i++) begin
      bt.data = 32'(b[i]);
      bt.last = (i == b.size() - 1);
      exp_n.push_back(bt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({n_if.valid_o, n_if.last_o, n_if.data_o, n_if.branch_map_flush_o, n_if.dropped_o} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got valid %b last %b data %h flush %b drop %b expected all 0",
               n_if.valid_o, n_if.last_o, n_if.data_o, n_if.branch_map_flush_o, n_if.dropped_o);
    end
    n_vec++;
    if ({w_if.valid_o, w_if.last_o, w_if.data_o} !== 34'h0) begin
      n_err++; $display("FAIL reset_outputs_wide: got valid %b last %b data %h expected 0", w_if.valid_o, w_if.last_o, w_if.data_o);
    end
    rst = 1'b0;
    n_last = '0; w_last = '0;
    @(posedge clk); #1;
    n_vec++;
    if (n_if.in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", n_if.in_ready_o); end
  endtask

  task automatic test_fmt2_diff();
    req_t r;
    int   hs;
    r = zero_req(); r.fmt = 2'd3; r.sf = 2'd0; r.priv = 2'd3; r.iaddr = 32'h1000_0000;
    send(r, 1'b0, 1'b1); drain(1'b0, 0, hs);
    r = zero_req(); r.fmt = 2'd2; r.iaddr = 32'h1000_0010; r.full_addr = 1'b0;
    push_lit('{8'h05, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00});
    send(r, 1'b0, 1'b0); drain(1'b0, 0, hs);
    n_vec++;
    if (hs != 6) begin n_err++; $display("FAIL fmt2_beats: got %0d expected 6", hs); end
  endtask

  task automatic test_fmt1_noaddr();
    req_t r;
    int   hs;
    r = zero_req(); r.fmt = 2'd1; r.branches = 5'd31; r.bmap = 31'h7FFF_FFFF;
    r.iaddr = 32'hDEAD_BEEC;
    push_lit('{8'h05, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'h3F});
    send(r, 1'b0, 1'b0);
    n_vec++;
    if (n_if.branch_map_flush_o !== 1'b1) begin n_err++; $display("FAIL flush_pulse: got %b expected 1", n_if.branch_map_flush_o); end
    drain(1'b0, 0, hs);
    // last_addr still 0x1000_0010, so a differential fmt 2 yields offset 0x10.
    r = zero_req(); r.fmt = 2'd2; r.iaddr = 32'h1000_0020;
    push_lit('{8'h05, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00});
    send(r, 1'b0, 1'b0); drain(1'b0, 0, hs);
  endtask

  task automatic test_trap_wide();
    req_t r;
    int   hs;
    r = zero_req(); r.fmt = 2'd3; r.sf = 2'd1; r.branch = 1'b1; r.priv = 2'd1;
    r.ecause = 5'h15; r.interrupt = 1'b1; r.thaddr = 1'b0;
    r.iaddr = 32'h8000_1234; r.tval = 32'hCAFE_F00D;
    send(r, 1'b1, 1'b1); drain(1'b1, 0, hs);
    n_vec++;
    if (hs != 3) begin n_err++; $display("FAIL trap_wide_beats: got %0d expected 3", hs); end
  endtask

  task automatic test_backpressure();
    req_t r;
    int   hs;
    r = zero_req(); r.fmt = 2'd3; r.sf = 2'd0; r.branch = 1'b1; r.priv = 2'd2; r.iaddr = 32'hA5C3_0F96;
    send(r, 1'b0, 1'b1); drain(1'b0, 1, hs);
    n_vec++;
    if (hs != 6) begin n_err++; $display("FAIL backpressure_handshakes: got %0d expected 6", hs); end
  endtask

  task automatic test_fmt0_drop();
    req_t r;
    int   hs;
    r = zero_req(); r.fmt = 2'd0; r.iaddr = 32'h5555_5550;
    send(r, 1'b0, 1'b1);
    n_vec++;
    if ({n_if.dropped_o, n_if.valid_o, n_if.in_ready_o} !== 3'b101) begin
      n_err++; $display("FAIL fmt0_drop: got dropped/valid/in_ready %b expected 101",
                        {n_if.dropped_o, n_if.valid_o, n_if.in_ready_o});
    end
    r = zero_req(); r.fmt = 2'd3; r.sf = 2'd3; r.ienable = 1'b1; r.qual = 2'd2; r.iopt = 4'h9;
    send(r, 1'b0, 1'b1);
    n_vec++;
    if ({n_if.dropped_o, n_if.valid_o} !== 2'b01) begin
      n_err++; $display("FAIL fmt0_next_accept: got dropped/valid %b expected 01", {n_if.dropped_o, n_if.valid_o});
    end
    drain(1'b0, 0, hs);
  endtask

  task automatic test_back_to_back();
    req_t r;
    int   hs;
    for (int i = 0; i < 3; i++) begin
      r = zero_req(); r.fmt = 2'd2; r.full_addr = 1'b1; r.iaddr = 32'h0100_0000 * (i + 1) + 32'h44;
      r.updiscon = i[0]; r.irreport = ~i[0];
      send(r, 1'b0, 1'b1); drain(1'b0, 0, hs);
      n_vec++;
      if (n_if.in_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_bubble%0d: in_ready got %b expected 1", i, n_if.in_ready_o); end
    end
  endtask

  task automatic test_reset_mid_frame();
    req_t  r;
    int    hs;
    beat_t e;
    r = zero_req(); r.fmt = 2'd3; r.sf = 2'd1; r.priv = 2'd3; r.ecause = 5'h0B;
    r.iaddr = 32'h1234_5678; r.tval = 32'h9ABC_DEF0;
    send(r, 1'b0, 1'b1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      e = exp_n.pop_front();
      n_vec++;
      if (n_if.valid_o !== 1'b1 || 32'(n_if.data_o) !== e.data || n_if.last_o !== e.last) begin
        n_err++; $display("FAIL midreset_beat%0d: got valid %b data %h expected data %h", b, n_if.valid_o, n_if.data_o, e.data);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_n.delete(); n_last = '0; w_last = '0;
    n_vec++;
    if ({n_if.valid_o, n_if.in_ready_o, n_if.last_o} !== 3'b010) begin
      n_err++; $display("FAIL midreset_state: got valid/in_ready/last %b expected 010",
                        {n_if.valid_o, n_if.in_ready_o, n_if.last_o});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({n_if.valid_o, n_if.in_ready_o} !== 2'b01) begin
      n_err++; $display("FAIL midreset_release: got valid/in_ready %b expected 01", {n_if.valid_o, n_if.in_ready_o});
    end
    r = zero_req(); r.fmt = 2'd3; r.sf = 2'd2; r.priv = 2'd0;
    push_lit('{8'h01, 8'h0B});
    send(r, 1'b0, 1'b0); drain(1'b0, 0, hs);
    // last_addr was cleared: a differential fmt 2 reports the full address.
    r = zero_req(); r.fmt = 2'd2; r.iaddr = 32'h2345_6780;
    push_lit('{8'h05, 8'h02, 8'h9E, 8'h15, 8'h8D, 8'h00});
    send(r, 1'b0, 1'b0); drain(1'b0, 0, hs);
  endtask

  task automatic test_random();
    req_t r;
    int   hs;
    for (int i = 0; i < 24; i++) begin
      r.fmt = 2'($urandom_range(0, 3)); r.sf = 2'($urandom_range(0, 3));
      r.branch = 1'($urandom); r.priv = PRIV_W'($urandom); r.iaddr = $urandom;
      r.ecause = CAUSE_W'($urandom); r.interrupt = 1'($urandom); r.thaddr = 1'($urandom);
      r.tval = $urandom; r.ienable = 1'($urandom); r.encoder_mode = 1'($urandom);
      r.qual = 2'($urandom); r.iopt = IOPT_W'($urandom);
      r.branches = BCNT_W'($urandom_range(0, BMAP_LEN)); r.bmap = BMAP_LEN'($urandom);
      r.updiscon = 1'($urandom); r.irreport = 1'($urandom); r.full_addr = 1'($urandom);
      send(r, 1'b0, 1'b1);
      if (r.fmt == 2'd0) begin
        n_vec++;
        if ({n_if.dropped_o, n_if.valid_o} !== 2'b10) begin
          n_err++; $display("FAIL rand_drop%0d: got dropped/valid %b expected 10", i, {n_if.dropped_o, n_if.valid_o});
        end
      end else begin
        drain(1'b0, int'($urandom_range(0, 1)), hs);
      end
    end
  endtask

  initial begin
    n_if.in_valid_i = 1'b0; w_if.in_valid_i = 1'b0;
    n_if.ready_i = 1'b1;    w_if.ready_i = 1'b1;
    apply(zero_req());
    test_reset();
    test_fmt2_diff();
    test_fmt1_noaddr();
    test_trap_wide();
    test_backpressure();
    test_fmt0_drop();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
